pc_sequencer: RTL and testbench

Fetch/next-PC controller for the single-cycle RISC-V core. It owns the architectural PC register and sequences each instruction through a fetch handshake with instruction memory and an execute/retire handshake with the datapath. It selects the next PC from sequential, branch, jump and trap sources, detects misaligned targets, supports halt/resume, and counts retired instructions.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 42 ++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_seq_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux and misaligned-target detection (purely combinational).
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_halt,
  input  logic [XLEN-1:0] i_trap_vector,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_take_trap,
  output logic [XLEN-1:0] o_bad_target
);

  logic            w_redirect;
  logic [XLEN-1:0] w_target;

  // Jump outranks a taken branch when choosing the redirect target.
  always_comb begin
    w_redirect = i_jump | i_branch_taken;
    w_target   = i_jump ? i_jump_target : i_branch_target;
  end

  // Trap check first, then halt, then redirect, then sequential.
  always_comb begin
    o_take_trap  = 1'b0;
    o_bad_target = '0;
    o_next_pc    = i_pc_plus4;
    if (w_redirect && is_misaligned(w_target)) begin
      o_take_trap  = 1'b1;
      o_bad_target = w_target;
      o_next_pc    = i_trap_vector;
    end else if (i_halt) begin
      o_next_pc = i_pc_plus4;
    end else if (w_redirect) begin
      o_next_pc = w_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC, runs fetch and retire handshakes,
// raises misaligned-target traps, supports halt/resume, counts retirements.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap_valid,
  output logic [31:0] trap_pc,
  output logic        halted,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_trap_valid;
  logic [31:0] r_trap_pc;
  logic [31:0] r_instret;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_take_trap;
  logic [31:0] w_bad_target;
  logic        w_fetch_done;
  logic        w_retire;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_fetch_done = (r_state == ST_FETCH) && imem_ack;
  assign w_retire     = (r_state == ST_EXEC) && retire;

  pc_next_sel u_next_sel (
    .i_pc_plus4      (w_pc_plus4),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_halt          (halt),
    .i_trap_vector   (TRAP_VECTOR),
    .o_next_pc       (w_next_pc),
    .o_take_trap     (w_take_trap),
    .o_bad_target    (w_bad_target)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_next;
  end

  // Next-state decode; a trap overrides halt and returns to fetch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT:  w_state_next = ST_FETCH;
      ST_FETCH: if (imem_ack) w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (retire) begin
          if (w_take_trap)  w_state_next = ST_FETCH;
          else if (halt)    w_state_next = ST_HALT;
          else              w_state_next = ST_FETCH;
        end
      end
      ST_HALT:  if (resume) w_state_next = ST_FETCH;
      default:  w_state_next = ST_BOOT;
    endcase
  end

  // PC, instruction latch, trap and retire-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_instr      <= '0;
      r_trap_valid <= 1'b0;
      r_trap_pc    <= '0;
      r_instret    <= '0;
    end else begin
      r_trap_valid <= 1'b0;
      if (w_fetch_done) r_instr <= imem_rdata;
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_instret <= r_instret + 32'd1;
        if (w_take_trap) begin
          r_trap_valid <= 1'b1;
          r_trap_pc    <= w_bad_target;
        end
      end
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_EXEC);
  assign halted      = (r_state == ST_HALT);
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign trap_valid  = r_trap_valid;
  assign trap_pc     = r_trap_pc;
  assign instret     = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with an instruction-level model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        retire;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halted;
  logic [31:0] instret;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .retire(retire),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .halted(halted), .instret(instret)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Architectural model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_instret;
  logic [31:0] m_trap_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = '0; retire = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; halt = 1'b0; resume = 1'b0;
  endtask

  task automatic random_controls();
    jump          = ($urandom_range(0, 3) == 0);
    branch_taken  = ($urandom_range(0, 3) == 0);
    halt          = ($urandom_range(0, 7) == 0);
    jump_target   = $urandom & 32'h0000_0FFF;
    branch_target = $urandom & 32'h0000_0FFF;
    if ($urandom_range(0, 3) != 0) jump_target[1:0] = 2'b00;
    if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
  endtask

  // One instruction: fetch handshake, execute wait, retire, optional halt.
  task automatic run_instr(input int unsigned n);
    int unsigned d, w, hc;
    logic [31:0] rd, tgt;
    logic        is_trap, is_halt;
    d = (n == 0) ? 0 : (n == 1) ? 3 : $urandom_range(0, 3);
    rd = '0;
    for (int k = 0; k <= int'(d); k++) begin
      check_eq("fetch_req", {31'b0, imem_req}, 32'd1);
      check_eq("fetch_addr", imem_addr, m_pc);
      check_eq("fetch_ivalid", {31'b0, instr_valid}, 32'd0);
      check_eq("fetch_instr_hold", instr, m_instr);
      rd = $urandom;
      imem_rdata = rd;
      imem_ack = (k == int'(d));
      retire = $urandom_range(0, 1);
      resume = $urandom_range(0, 1);
      step();
    end
    m_instr = rd;
    clear_inputs();

    w = (n < 2) ? 0 : $urandom_range(0, 2);
    for (int k = 0; k <= int'(w); k++) begin
      check_eq("exec_ivalid", {31'b0, instr_valid}, 32'd1);
      check_eq("exec_instr", instr, m_instr);
      check_eq("exec_req", {31'b0, imem_req}, 32'd0);
      check_eq("exec_pc", pc, m_pc);
      check_eq("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
      random_controls();
      imem_ack = $urandom_range(0, 1);
      imem_rdata = $urandom;
      resume = $urandom_range(0, 1);
      retire = (k == int'(w));
      if (retire) begin
        case (n)
          0, 1, 9: begin jump = 0; branch_taken = 0; halt = 0; end
          2: begin jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80; halt = 0; end
          4: begin jump = 0; branch_taken = 1; branch_target = 32'h22; halt = 0; end
          6: begin jump = 0; branch_taken = 0; halt = 1; end
          8: begin jump = 1; jump_target = 32'hFFFF_FFFC; branch_taken = 0; halt = 0; end
          default: ;
        endcase
      end
      step();
    end

    // Model of the retirement rules.
    tgt     = jump ? jump_target : branch_target;
    is_trap = (jump || branch_taken) && (tgt % 4 != 0);
    is_halt = !is_trap && halt;
    m_instret = m_instret + 1;
    if (is_trap) begin
      m_pc = 32'h100;
      m_trap_pc = tgt;
    end else if (halt || !(jump || branch_taken)) begin
      m_pc = m_pc + 4;
    end else begin
      m_pc = tgt;
    end
    clear_inputs();

    check_eq("retire_pc", pc, m_pc);
    check_eq("retire_instret", instret, m_instret);
    check_eq("retire_trap_valid", {31'b0, trap_valid}, {31'b0, is_trap});
    check_eq("retire_trap_pc", trap_pc, m_trap_pc);
    check_eq("retire_halted", {31'b0, halted}, {31'b0, is_halt});

    if (is_trap) begin
      step();
      check_eq("trap_pulse_end", {31'b0, trap_valid}, 32'd0);
    end

    if (is_halt) begin
      hc = (n == 6) ? 5 : $urandom_range(1, 4);
      for (int h = 0; h < int'(hc); h++) begin
        check_eq("halt_halted", {31'b0, halted}, 32'd1);
        check_eq("halt_req", {31'b0, imem_req}, 32'd0);
        check_eq("halt_pc", pc, m_pc);
        imem_ack = $urandom_range(0, 1);
        retire = $urandom_range(0, 1);
        step();
      end
      clear_inputs();
      resume = 1'b1;
      step();
      resume = 1'b0;
      check_eq("resume_halted", {31'b0, halted}, 32'd0);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_pc = 32'h0; m_instr = '0; m_instret = '0; m_trap_pc = '0;

    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc_plus4", pc_plus4, 32'h4);
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_trap_valid", {31'b0, trap_valid}, 32'd0);
    check_eq("rst_trap_pc", trap_pc, 32'h0);
    check_eq("rst_halted", {31'b0, halted}, 32'd0);
    check_eq("rst_instret", instret, 32'h0);
    step();

    for (int unsigned n = 0; n < 40; n++) run_instr(n);

    // Reset during fetch, then an ack during BOOT must be ignored.
    check_eq("pre_rst_req", {31'b0, imem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_pc", pc, 32'h0);
    check_eq("midrst_req", {31'b0, imem_req}, 32'd0);
    check_eq("midrst_instret", instret, 32'h0);
    check_eq("midrst_instr", instr, 32'h0);
    check_eq("midrst_trap_pc", trap_pc, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    clear_inputs();
    check_eq("postrst_req", {31'b0, imem_req}, 32'd1);
    check_eq("postrst_addr", imem_addr, 32'h0);
    check_eq("postrst_instr", instr, 32'h0);
    check_eq("postrst_ivalid", {31'b0, instr_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
